distance_loader: RTL and testbench

Front-end stage feeding the `top` distance-table write port (`distance_write` / `distance_w_addr` / `distance_w_data`). It accepts a full row-major N×N city distance matrix as a valid/ready stream. It keeps only the strict lower triangle (column < row) and emits one write per kept element, with a linearly incrementing address. Diagonal and upper-triangle beats are consumed and discarded, so the host can stream the raw matrix without pre-filtering.

---
 rtl/replica_pkg.sv | 10 +
 rtl/distance_loader_if.sv | 35 +++
 rtl/distance_loader.sv | 171 +++++++++++++++++
 tb/tb_distance_loader.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/replica_pkg.sv
// replica_pkg: shared sizing constants and data types for the distance-table
// datapath. city_num_log sizes row/column counters (31 cities + 1 fits in 5
// bits). distance_data_t is one distance-matrix element.
package replica_pkg;

  localparam int city_num_log = 5;

  typedef logic [15:0] distance_data_t;

endpackage : replica_pkg

// File: rtl/distance_loader_if.sv
// distance_loader_if: bundles the matrix input stream (s_valid/s_ready/s_data)
// and the distance-table write port (distance_write/_w_addr/_w_data).
// The slave modport is the loader's side; the master modport is the side that
// sources the stream and observes the writes.
interface distance_loader_if #(
  parameter int CITY_W = replica_pkg::city_num_log
);

  logic                        s_valid;
  logic                        s_ready;
  replica_pkg::distance_data_t s_data;

  logic                        distance_write;
  logic [2*CITY_W-1:0]         distance_w_addr;
  replica_pkg::distance_data_t distance_w_data;

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready,
    output distance_write,
    output distance_w_addr,
    output distance_w_data
  );

  modport master (
    output s_valid,
    output s_data,
    input  s_ready,
    input  distance_write,
    input  distance_w_addr,
    input  distance_w_data
  );

endinterface : distance_loader_if

// File: rtl/distance_loader.sv
// distance_loader: consumes a row-major N x N distance matrix as a valid/ready
// stream and forwards only the strict lower triangle (column < row) to the
// distance-table write port with a linearly incrementing address.
// Diagonal and upper-triangle beats are accepted and dropped.
//
// Optional feature macro: DISTANCE_LOADER_DIAG_CHECK_EN
//   defined   -> diag_err latches when a diagonal beat carries non-zero data
//   undefined -> diag_err is tied low and no comparator exists
module distance_loader #(
  parameter int NCITY  = 31,
  parameter int CITY_W = replica_pkg::city_num_log
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CITY_W-1:0] size,
  input  logic              abort,
  distance_loader_if.slave  bus,
  output logic              busy,
  output logic              done,
  output logic              diag_err
);

  import replica_pkg::*;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  localparam logic [CITY_W-1:0]   N_MAX = CITY_W'(NCITY);
  localparam logic [CITY_W-1:0]   ONE_C = CITY_W'(1);
  localparam logic [2*CITY_W-1:0] ONE_A = (2*CITY_W)'(1);

  state_t              state;
  logic [CITY_W-1:0]   last_q;     // N-1, index of the last row/column
  logic [CITY_W-1:0]   i_q;        // row counter
  logic [CITY_W-1:0]   j_q;        // column counter
  logic [2*CITY_W-1:0] wa_q;       // next write address
  logic [2*CITY_W-1:0] addr_q;
  distance_data_t      data_q;
  logic                s_ready_q;
  logic                wr_q;
  logic                busy_q;
  logic                done_q;

  logic                accept;
  logic [CITY_W-1:0]   size_lim;

  // s_ready is only ever high in LOAD, so it doubles as the LOAD qualifier.
  assign accept   = s_ready_q & bus.s_valid;
  // A size beyond the table capacity is clamped so addresses never overflow.
  assign size_lim = (size > N_MAX) ? N_MAX : size;

  // Load sequencer: state, counters and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: every register here, including the address/data holding
    // registers, has a defined reset value because the downstream table
    // observes these outputs directly; state uses <= so all updates in this
    // block see the pre-edge values regardless of statement order.
    if (!reset) begin
      state     <= IDLE;
      last_q    <= '0;
      i_q       <= '0;
      j_q       <= '0;
      wa_q      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      s_ready_q <= 1'b0;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // Strobes are single-cycle; address/data simply hold.
      wr_q   <= 1'b0;
      done_q <= 1'b0;

      if (abort) begin
        // abort beats start and any beat offered this cycle.
        state     <= IDLE;
        i_q       <= '0;
        j_q       <= '0;
        wa_q      <= '0;
        s_ready_q <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              i_q    <= '0;
              j_q    <= '0;
              wa_q   <= '0;
              last_q <= size_lim - ONE_C;
              if (size >= CITY_W'(2)) begin
                state     <= LOAD;
                s_ready_q <= 1'b1;
                busy_q    <= 1'b1;
              end else begin
                // Nothing to load: report completion straight away.
                state  <= DONE;
                done_q <= 1'b1;
              end
            end
          end

          LOAD: begin
            if (accept) begin
              if (j_q < i_q) begin
                wr_q   <= 1'b1;
                addr_q <= wa_q;
                data_q <= bus.s_data;
                wa_q   <= wa_q + ONE_A;
              end
              if (j_q == last_q) begin
                j_q <= '0;
                if (i_q == last_q) begin
                  // (N-1, N-1) is always the final beat.
                  state     <= DONE;
                  s_ready_q <= 1'b0;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                end else begin
                  i_q <= i_q + ONE_C;
                end
              end else begin
                j_q <= j_q + ONE_C;
              end
            end
          end

          DONE: begin
            state <= IDLE;
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef DISTANCE_LOADER_DIAG_CHECK_EN
  logic diag_q;

  // Sticky diagonal check: set by a non-zero diagonal beat, cleared by the
  // next accepted start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      diag_q <= 1'b0;
    end else if (!abort && state == IDLE && start) begin
      diag_q <= 1'b0;
    end else if (!abort && accept && i_q == j_q && bus.s_data != '0) begin
      diag_q <= 1'b1;
    end
  end

  assign diag_err = diag_q;
`else
  assign diag_err = 1'b0;
`endif

  assign bus.s_ready         = s_ready_q;
  assign bus.distance_write  = wr_q;
  assign bus.distance_w_addr = addr_q;
  assign bus.distance_w_data = data_q;
  assign busy                = busy_q;
  assign done                = done_q;

endmodule : distance_loader

// File: tb/tb_distance_loader.sv
// tb_distance_loader: directed bench for distance_loader. Inputs change 2 ns
// after a rising edge; a monitor samples outputs on the falling edge and
// records writes, busy/ready cycles and done timing for the scenario tasks.
module tb_distance_loader;

  localparam int CITY_W = 5;

`ifdef DISTANCE_LOADER_DIAG_CHECK_EN
  localparam logic DIAG_EXP = 1'b1;
`else
  localparam logic DIAG_EXP = 1'b0;
`endif

  logic              clk   = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [CITY_W-1:0] size  = '0;
  logic              busy;
  logic              done;
  logic              diag_err;

  distance_loader_if #(.CITY_W(CITY_W)) bus ();

  distance_loader #(
    .NCITY (31),
    .CITY_W(CITY_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .size    (size),
    .abort   (abort),
    .bus     (bus.slave),
    .busy    (busy),
    .done    (done),
    .diag_err(diag_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Monitor state.
  int          cyc = 0;        // rising-edge index
  int          wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  int          busy_cnt, ready_cnt, done_cnt, done_cyc, bad_wr;
  int          last_acc = -1;  // edge index at which the latest beat was taken
  int          start_edge = -1;
  logic        acc_prev = 1'b0;

  logic [15:0] stim[$];

  always @(posedge clk) cyc++;

  // Falling-edge monitor; an output registered at edge p is seen here with cyc == p.
  always @(negedge clk) begin
    if (bus.distance_write) begin
      wr_addr_q.push_back(int'(bus.distance_w_addr));
      wr_data_q.push_back(bus.distance_w_data);
      if (!acc_prev) bad_wr++;
    end
    if (busy) busy_cnt++;
    if (bus.s_ready) ready_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    acc_prev = bus.s_valid && bus.s_ready && !abort;
    if (acc_prev) last_acc = cyc + 1;
  end

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_data_q.delete();
    busy_cnt  = 0;
    ready_cnt = 0;
    done_cnt  = 0;
    done_cyc  = -1;
    bad_wr    = 0;
  endtask

  task automatic do_start(input int n);
    start      = 1'b1;
    size       = CITY_W'(n);
    start_edge = cyc + 1;
    tick();
    start      = 1'b0;
  endtask

  // Offers every element of stim in order; with stall set, an idle cycle
  // precedes every beat after the first.
  task automatic drive_stream(input bit stall);
    for (int k = 0; k < stim.size(); k++) begin
      int w;
      w = 0;
      if (stall && k > 0) begin
        bus.s_valid = 1'b0;
        tick();
      end
      bus.s_valid = 1'b1;
      bus.s_data  = stim[k];
      while (!bus.s_ready && w < 20) begin
        tick();
        w++;
      end
      if (!bus.s_ready) begin
        checks++;
        errors++;
        $display("FAIL stream_ready_timeout beat=%0d s_ready=%0b required=1", k, bus.s_ready);
        bus.s_valid = 1'b0;
        return;
      end
      tick();
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus.s_ready, bus.distance_write, busy, done, diag_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b required=00000",
               {bus.s_ready, bus.distance_write, busy, done, diag_err});
    end
    checks++;
    if (bus.distance_w_addr !== '0) begin
      errors++;
      $display("FAIL reset_addr got=%0d required=0", bus.distance_w_addr);
    end
    checks++;
    if (bus.distance_w_data !== '0) begin
      errors++;
      $display("FAIL reset_data got=%0d required=0", bus.distance_w_data);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int exp_d[3] = '{1, 2, 3};
    clear_mon();
    stim = '{16'd0, 16'd1, 16'd2, 16'd1, 16'd0, 16'd3, 16'd2, 16'd3, 16'd0};
    do_start(3);
    checks++;
    if (bus.s_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_start_latency s_ready=%0b busy=%0b required=1,1", bus.s_ready, busy);
    end
    drive_stream(1'b0);
    tick();
    tick();
    checks++;
    if (wr_addr_q.size() != 3) begin
      errors++;
      $display("FAIL basic_write_count got=%0d required=3", wr_addr_q.size());
    end
    for (int k = 0; k < 3 && k < wr_addr_q.size(); k++) begin
      checks++;
      if (wr_addr_q[k] !== k || wr_data_q[k] !== 16'(exp_d[k])) begin
        errors++;
        $display("FAIL basic_write[%0d] got=(%0d,%0d) required=(%0d,%0d)",
                 k, wr_addr_q[k], wr_data_q[k], k, exp_d[k]);
      end
    end
    checks++;
    if (done_cnt != 1 || done_cyc != last_acc) begin
      errors++;
      $display("FAIL basic_done count=%0d at=%0d required=1 at=%0d", done_cnt, done_cyc, last_acc);
    end
    checks++;
    if (busy_cnt != 9) begin
      errors++;
      $display("FAIL basic_busy_cycles got=%0d required=9", busy_cnt);
    end
    checks++;
    if (bus.distance_w_addr !== 10'd2 || bus.distance_w_data !== 16'd3) begin
      errors++;
      $display("FAIL basic_hold got=(%0d,%0d) required=(2,3)",
               bus.distance_w_addr, bus.distance_w_data);
    end
    checks++;
    if (bus.s_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle s_ready=%0b busy=%0b required=0,0", bus.s_ready, busy);
    end
  endtask

  task automatic test_full_size();
    int          k;
    logic [15:0] expd;
    clear_mon();
    stim.delete();
    for (int i = 0; i < 31; i++)
      for (int j = 0; j < 31; j++) stim.push_back(16'(i * 31 + j));
    do_start(31);
    drive_stream(1'b0);
    tick();
    tick();
    checks++;
    if (wr_addr_q.size() != 465) begin
      errors++;
      $display("FAIL full_write_count got=%0d required=465", wr_addr_q.size());
    end
    k = 0;
    for (int i = 1; i < 31; i++) begin
      for (int j = 0; j < i; j++) begin
        if (k < wr_addr_q.size()) begin
          expd = 16'(i * 31 + j);
          checks++;
          if (wr_addr_q[k] !== k || wr_data_q[k] !== expd) begin
            errors++;
            $display("FAIL full_write[%0d] got=(%0d,%0d) required=(%0d,%0d)",
                     k, wr_addr_q[k], wr_data_q[k], k, expd);
          end
        end
        k++;
      end
    end
    checks++;
    if (busy_cnt != 961) begin
      errors++;
      $display("FAIL full_busy_cycles got=%0d required=961", busy_cnt);
    end
    checks++;
    if (done_cnt != 1 || done_cyc != last_acc) begin
      errors++;
      $display("FAIL full_done count=%0d at=%0d required=1 at=%0d", done_cnt, done_cyc, last_acc);
    end
  endtask

  task automatic test_stalled();
    int exp_d[6] = '{11, 21, 22, 31, 32, 33};
    clear_mon();
    stim.delete();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) stim.push_back(16'(i * 10 + j + 1));
    do_start(4);
    drive_stream(1'b1);
    tick();
    tick();
    checks++;
    if (wr_addr_q.size() != 6) begin
      errors++;
      $display("FAIL stall_write_count got=%0d required=6", wr_addr_q.size());
    end
    for (int k = 0; k < 6 && k < wr_addr_q.size(); k++) begin
      checks++;
      if (wr_addr_q[k] !== k || wr_data_q[k] !== 16'(exp_d[k])) begin
        errors++;
        $display("FAIL stall_write[%0d] got=(%0d,%0d) required=(%0d,%0d)",
                 k, wr_addr_q[k], wr_data_q[k], k, exp_d[k]);
      end
    end
    checks++;
    if (bad_wr != 0) begin
      errors++;
      $display("FAIL stall_write_after_idle got=%0d required=0", bad_wr);
    end
    checks++;
    if (done_cnt != 1 || done_cyc != last_acc) begin
      errors++;
      $display("FAIL stall_done count=%0d at=%0d required=1 at=%0d", done_cnt, done_cyc, last_acc);
    end
  endtask

  task automatic test_degenerate();
    int sizes[2] = '{1, 0};
    for (int s = 0; s < 2; s++) begin
      clear_mon();
      bus.s_valid = 1'b1;
      bus.s_data  = 16'd99;
      do_start(sizes[s]);
      tick();
      tick();
      bus.s_valid = 1'b0;
      checks++;
      if (ready_cnt != 0 || wr_addr_q.size() != 0 || busy_cnt != 0) begin
        errors++;
        $display("FAIL degen_size%0d ready=%0d writes=%0d busy=%0d required=0,0,0",
                 sizes[s], ready_cnt, wr_addr_q.size(), busy_cnt);
      end
      checks++;
      if (done_cnt != 1 || done_cyc != start_edge) begin
        errors++;
        $display("FAIL degen_done_size%0d count=%0d at=%0d required=1 at=%0d",
                 sizes[s], done_cnt, done_cyc, start_edge);
      end
    end
  endtask

  task automatic test_abort();
    clear_mon();
    stim = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd11};
    do_start(4);
    drive_stream(1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    tick();
    checks++;
    if (wr_addr_q.size() != 1) begin
      errors++;
      $display("FAIL abort_write_count got=%0d required=1", wr_addr_q.size());
    end else begin
      checks++;
      if (wr_addr_q[0] !== 0 || wr_data_q[0] !== 16'd11) begin
        errors++;
        $display("FAIL abort_write got=(%0d,%0d) required=(0,11)", wr_addr_q[0], wr_data_q[0]);
      end
    end
    checks++;
    if (done_cnt != 0 || busy !== 1'b0 || bus.s_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle done=%0d busy=%0b s_ready=%0b required=0,0,0",
               done_cnt, busy, bus.s_ready);
    end

    // Restart after abort begins again at address 0.
    clear_mon();
    stim = '{16'd5, 16'd6, 16'd7, 16'd8};
    do_start(2);
    drive_stream(1'b0);
    tick();
    tick();
    checks++;
    if (wr_addr_q.size() != 1 || done_cnt != 1) begin
      errors++;
      $display("FAIL restart_counts writes=%0d done=%0d required=1,1", wr_addr_q.size(), done_cnt);
    end else begin
      checks++;
      if (wr_addr_q[0] !== 0 || wr_data_q[0] !== 16'd7) begin
        errors++;
        $display("FAIL restart_write got=(%0d,%0d) required=(0,7)", wr_addr_q[0], wr_data_q[0]);
      end
    end

    // abort together with start: abort wins.
    clear_mon();
    abort = 1'b1;
    do_start(3);
    abort = 1'b0;
    tick();
    checks++;
    if (busy_cnt != 0 || ready_cnt != 0 || done_cnt != 0) begin
      errors++;
      $display("FAIL abort_with_start busy=%0d ready=%0d done=%0d required=0,0,0",
               busy_cnt, ready_cnt, done_cnt);
    end
  endtask

  task automatic test_diag_and_reset();
    clear_mon();
    stim = '{16'd0, 16'd1, 16'd2, 16'd1, 16'd7, 16'd3, 16'd2, 16'd3, 16'd0};
    do_start(3);
    drive_stream(1'b0);
    tick();
    tick();
    checks++;
    if (diag_err !== DIAG_EXP || done_cnt != 1) begin
      errors++;
      $display("FAIL diag_after_done diag_err=%0b done=%0d required=%0b,1", diag_err, done_cnt, DIAG_EXP);
    end
    checks++;
    if (wr_addr_q.size() != 3 || (wr_data_q.size() == 3 && wr_data_q[2] !== 16'd3)) begin
      errors++;
      $display("FAIL diag_dataflow writes=%0d required=3", wr_addr_q.size());
    end

    // A new start clears the flag; the bad diagonal sets it again.
    clear_mon();
    do_start(3);
    checks++;
    if (diag_err !== 1'b0) begin
      errors++;
      $display("FAIL diag_cleared_on_start got=%0b required=0", diag_err);
    end
    stim = '{16'd0, 16'd1, 16'd2, 16'd1, 16'd7};
    drive_stream(1'b0);
    checks++;
    if (diag_err !== DIAG_EXP || busy !== 1'b1 || bus.distance_write !== 1'b0) begin
      errors++;
      $display("FAIL diag_midload diag_err=%0b busy=%0b write=%0b required=%0b,1,0",
               diag_err, busy, bus.distance_write, DIAG_EXP);
    end

    // Asynchronous reset mid-load clears everything without a clock edge.
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.s_ready, bus.distance_write, busy, done, diag_err} !== 5'b0 ||
        bus.distance_w_addr !== '0 || bus.distance_w_data !== '0) begin
      errors++;
      $display("FAIL async_reset flags=%b addr=%0d data=%0d required=00000,0,0",
               {bus.s_ready, bus.distance_write, busy, done, diag_err},
               bus.distance_w_addr, bus.distance_w_data);
    end
    tick();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || bus.s_ready !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle busy=%0b s_ready=%0b done=%0b required=0,0,0",
               busy, bus.s_ready, done);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_size();
    test_stalled();
    test_degenerate();
    test_abort();
    test_diag_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout time=%0t required=finish_before_500000", $time);
    $fatal(1, "watchdog");
  end

endmodule : tb_distance_loader
